seg7_bus_display: RTL and testbench
===================================

// Module: seg7_bus_display
// PURPOSE
//  Bus-mapped, parametrised multiplexed seven-segment display peripheral for the microprocessor system.
//  Replaces the fixed 4-digit, hard-wired display controller.
//  The Processor writes per-digit value, blank and decimal-point registers and a control register over BUS_DATA/BUS_ADDR/BUS_WE.
//  The block scans NUM_DIGITS digits with frame-coherent update, anti-ghost blanking and 16-level PWM brightness.
// PARAMETERS
//  NUM_DIGITS    4           digits scanned, 1..8
//  BASE_ADDR     8'hD0       bus address of DIGIT[0]; DIGIT[i] at BASE_ADDR+i; CTRL at BASE_ADDR+NUM_DIGITS
//  CLK_FREQ_HZ   50_000_000  CLK frequency
//  REFRESH_HZ    1000        full-frame refresh rate; SLOT_CYCLES = CLK_FREQ_HZ/(REFRESH_HZ*NUM_DIGITS)
//  BLANK_CYCLES  64          cycles at the start of each slot with all anodes off
//  Elaboration error if SLOT_CYCLES <= BLANK_CYCLES, NUM_DIGITS outside 1..8, or BASE_ADDR+NUM_DIGITS > 8'hFF.
// PORTS
//  CLK             in     1           system clock (clk_sys, 50 MHz)
//  RESET           in     1           synchronous, active-high reset
//  BUS_DATA        inout  8           processor data bus; driven only during a read of this block, else 'Z
//  BUS_ADDR        in     8           processor address bus
//  BUS_WE          in     1           1 = write cycle, 0 = read
//  SEG_SELECT_OUT  out    NUM_DIGITS  active-low anodes; bit 0 = rightmost digit
//  HEX_OUT         out    8           active-low segments {dp,g,f,e,d,c,b,a}
//  FRAME_STROBE    out    1           1-cycle pulse when the shadow registers are reloaded
// BEHAVIOUR
//  Registers:
//   - DIGIT[i]: [3:0] hex nibble, [4] blank, [7] dp on; [6:5] read 0. Reset 8'h10 (blanked).
//   - CTRL: [0] enable, [7:4] brightness B; [3:1] read 0. Reset 8'hF0.
//  Write: on any CLK edge with BUS_WE=1 and BUS_ADDR in range, the register updates on that edge.
//   Out-of-range addresses are ignored; unused bits are dropped.
//  Read: BUS_WE=0 with BUS_ADDR in range at edge n -> BUS_DATA driven with the register value from edge n to edge n+1 (1-cycle latency).
//   Data and output enable are both registered; otherwise BUS_DATA='Z.
//  Scan timer:
//   - slot_cnt runs 0..SLOT_CYCLES-1 and wraps; digit index d advances 0..NUM_DIGITS-1 and wraps on each slot_cnt wrap.
//   - Reset: slot_cnt=0, d=0.
//  Frame coherence:
//   - When d wraps to 0 (and on the first cycle after reset), all DIGIT registers copy to shadows and FRAME_STROBE pulses.
//   - A write on that same edge is not captured; it appears next frame.
//   - CTRL is not shadowed; it takes effect on the next edge.
//  Output, registered, computed from shadow[d]:
//   - HEX_OUT = ~{dp, decode(nibble)}.
//   - SEG_SELECT_OUT[d] = 0 only when all hold: slot_cnt >= BLANK_CYCLES, enable=1, blank=0, pwm_cnt <= B.
//   - All other anodes are 1.
//  PWM: pwm_cnt is a 4-bit free-running counter, reset 0, wraps 15->0. B=15 gives 100% duty, B=0 gives 1/16.
//  Decode {a..g}: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
//  Reset values: SEG_SELECT_OUT all 1s, HEX_OUT 8'hFF, FRAME_STROBE 0, BUS_DATA 'Z. Registers and shadows take their reset values.
//  RESET mid-scan: all of the above on the next edge; the scan restarts at digit 0, slot_cnt 0.
//  Simultaneous read and write cannot occur (BUS_WE exclusive). A write during an active read slot does not alter the data already latched.
// STRUCTURE
//  Package seg7_pkg: CTRL bit-position constants, DIGIT field constants, and function seg7_decode(logic [3:0]) -> logic [6:0].
//  Sub-module seg7_scan_timer: slot_cnt, digit index, frame_start, active window.
//  The top level holds the bus register file, shadows, PWM and output registers.
// TESTING  (NUM_DIGITS=4, CLK_FREQ_HZ=6400, REFRESH_HZ=100 -> SLOT_CYCLES=16; BLANK_CYCLES=2)
//  1. Reset, no writes.
//     -> SEG_SELECT_OUT=4'hF and HEX_OUT=8'hFF throughout; reads of D0..D4 return 10,10,10,10,F0 one cycle after address.
//  2. Write D0=8'h00, D1=8'h88, CTRL=8'hF1; wait one frame.
//     -> digit 0 slot: HEX_OUT=8'hC0, anode 4'hE from slot cycle 2..15.
//     -> digit 1 slot: HEX_OUT=8'h00.
//     -> digits 2,3 anodes stay high.
//  3. CTRL=8'h31 (B=3).
//     -> anode low for exactly 4 of every 16 consecutive pwm_cnt values during the active window.
//  4. Write D0=8'h05 on the exact FRAME_STROBE edge.
//     -> current frame still shows the old value; the next frame shows 8'h92.
//  5. Write to BASE_ADDR+5 and 8'h00.
//     -> no register change; BUS_DATA stays 'Z on reads of those addresses.
//  6. Assert RESET for 1 cycle in the middle of digit 2's slot.
//     -> next edge: outputs all 1s, registers at reset values, FRAME_STROBE pulses one cycle later, scan resumes at digit 0.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: register field positions, reset values and hex-to-segment decode for seg7_bus_display
package seg7_pkg;
  localparam int CTRL_EN = 0;
  localparam int CTRL_B_LSB = 4;
  localparam int DIG_BLANK = 4;
  localparam int DIG_DP = 7;
  localparam logic [7:0] DIG_MASK = 8'h9F;
  localparam logic [7:0] CTRL_MASK = 8'hF1;
  localparam logic [7:0] DIG_RST = 8'h10;
  localparam logic [7:0] CTRL_RST = 8'hF0;
  typedef struct packed {
    logic       dp;
    logic       blank;
    logic [3:0] nib;
  } digit_t;
  localparam digit_t DIG_SH_RST = '{dp: 1'b0, blank: 1'b1, nib: 4'h0};
  function automatic logic [6:0] seg7_decode(input logic [3:0] v);
    case (v)
      4'h0: return 7'h3F;
      4'h1: return 7'h06;
      4'h2: return 7'h5B;
      4'h3: return 7'h4F;
      4'h4: return 7'h66;
      4'h5: return 7'h6D;
      4'h6: return 7'h7D;
      4'h7: return 7'h07;
      4'h8: return 7'h7F;
      4'h9: return 7'h6F;
      4'hA: return 7'h77;
      4'hB: return 7'h7C;
      4'hC: return 7'h39;
      4'hD: return 7'h5E;
      4'hE: return 7'h79;
      default: return 7'h71;
    endcase
  endfunction
endpackage

// File: rtl/seg7_scan_timer.sv
// seg7_scan_timer: slot counter and digit index for the multiplexed scan
//   clk, rst     clock, synchronous active-high reset
//   digit        digit index currently being scanned
//   frame_start  high on the cycle whose edge reloads the shadows (first cycle after reset, or d wrapping)
//   active       slot is past the anti-ghost blanking window
module seg7_scan_timer #(
  parameter int SLOT_CYCLES = 16,
  parameter int NUM_DIGITS = 4,
  parameter int BLANK_CYCLES = 2,
  parameter int DW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  output logic [DW-1:0] digit,
  output logic          frame_start,
  output logic          active
);
  localparam int SW = SLOT_CYCLES > 1 ? $clog2(SLOT_CYCLES) : 1;
  logic [SW-1:0] slot_cnt;
  logic first, slot_wrap, dig_wrap;
  assign slot_wrap = slot_cnt == SW'(SLOT_CYCLES - 1);
  assign dig_wrap = slot_wrap && digit == DW'(NUM_DIGITS - 1);
  assign frame_start = first || dig_wrap;
  assign active = slot_cnt >= SW'(BLANK_CYCLES);
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt <= '0;
      digit <= '0;
      first <= 1'b1;
    end else begin
      slot_cnt <= slot_wrap ? '0 : slot_cnt + 1'b1;
      digit <= dig_wrap ? '0 : slot_wrap ? digit + 1'b1 : digit;
      first <= 1'b0;
    end
  end
endmodule

// File: rtl/seg7_bus_display.sv
// seg7_bus_display: bus-mapped multiplexed seven-segment display with frame-coherent shadows and PWM brightness
//   CLK, RESET      clock, synchronous active-high reset
//   BUS_DATA        bidirectional data, driven only for the cycle after an in-range read
//   BUS_ADDR/WE     DIGIT[i] at BASE_ADDR+i, CTRL at BASE_ADDR+NUM_DIGITS
//   SEG_SELECT_OUT  active-low anodes, bit 0 rightmost
//   HEX_OUT         active-low segments {dp,g,f,e,d,c,b,a}
//   FRAME_STROBE    one-cycle pulse after the shadows reload
module seg7_bus_display
  import seg7_pkg::*;
#(
  parameter int         NUM_DIGITS = 4,
  parameter logic [7:0] BASE_ADDR = 8'hD0,
  parameter int         CLK_FREQ_HZ = 50_000_000,
  parameter int         REFRESH_HZ = 1000,
  parameter int         BLANK_CYCLES = 64
) (
  input  logic                  CLK,
  input  logic                  RESET,
  inout  wire  [7:0]            BUS_DATA,
  input  logic [7:0]            BUS_ADDR,
  input  logic                  BUS_WE,
  output logic [NUM_DIGITS-1:0] SEG_SELECT_OUT,
  output logic [7:0]            HEX_OUT,
  output logic                  FRAME_STROBE
);
  localparam int SLOT_CYCLES = CLK_FREQ_HZ / (REFRESH_HZ * NUM_DIGITS);
  localparam int DW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  if (SLOT_CYCLES <= BLANK_CYCLES || NUM_DIGITS < 1 || NUM_DIGITS > 8 || BASE_ADDR + NUM_DIGITS > 255) begin : g_bad_params
    $error("seg7_bus_display: illegal parameter combination");
  end
  logic [7:0] digits [NUM_DIGITS];
  digit_t shadow [NUM_DIGITS];
  digit_t cur;
  logic [7:0] ctrl, rd_data, off;
  logic [3:0] pwm_cnt;
  logic [DW-1:0] digit;
  logic rd_oe, hit, frame_start, active, lit;
  assign off = BUS_ADDR - BASE_ADDR;
  assign hit = BUS_ADDR >= BASE_ADDR && off <= 8'(NUM_DIGITS);
  assign cur = shadow[digit];
  assign lit = active && ctrl[CTRL_EN] && !cur.blank && pwm_cnt <= ctrl[CTRL_B_LSB +: 4];
  assign BUS_DATA = rd_oe ? rd_data : 'z;
  seg7_scan_timer #(
    .SLOT_CYCLES(SLOT_CYCLES),
    .NUM_DIGITS(NUM_DIGITS),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .clk(CLK),
    .rst(RESET),
    .digit(digit),
    .frame_start(frame_start),
    .active(active)
  );
  always_ff @(posedge CLK) begin
    if (RESET) begin
      digits <= '{default: DIG_RST};
      shadow <= '{default: DIG_SH_RST};
      ctrl <= CTRL_RST;
      rd_oe <= 1'b0;
      rd_data <= '0;
      pwm_cnt <= '0;
      SEG_SELECT_OUT <= '1;
      HEX_OUT <= 8'hFF;
      FRAME_STROBE <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (BUS_WE && hit && off == 8'(i)) digits[i] <= BUS_DATA & DIG_MASK;
        if (frame_start) shadow[i] <= '{dp: digits[i][DIG_DP], blank: digits[i][DIG_BLANK], nib: digits[i][3:0]};
      end
      if (BUS_WE && hit && off == 8'(NUM_DIGITS)) ctrl <= BUS_DATA & CTRL_MASK;
      rd_oe <= !BUS_WE && hit;
      if (!BUS_WE && hit) rd_data <= off == 8'(NUM_DIGITS) ? ctrl : digits[off[DW-1:0]];
      pwm_cnt <= pwm_cnt + 4'd1;
      SEG_SELECT_OUT <= lit ? ~(NUM_DIGITS'(1) << digit) : '1;
      HEX_OUT <= cur.blank ? 8'hFF : ~{cur.dp, seg7_decode(cur.nib)};
      FRAME_STROBE <= frame_start;
    end
  end
endmodule

// File: tb/tb_seg7_bus_display.sv
// tb_seg7_bus_display: randomized and directed bus traffic checked cycle by cycle against a time-based reference model
module tb_seg7_bus_display;
  localparam logic [7:0] BASE = 8'hD0;
  localparam int ND = 4, SLOT = 16, BLANK = 2, FRAME = SLOT * ND;
  logic CLK = 1'b0, RESET = 1'b0, BUS_WE = 1'b0, tb_oe = 1'b0, last_rd = 1'b0;
  logic [7:0] BUS_ADDR = 8'h00, tb_data = 8'h00;
  wire [7:0] BUS_DATA;
  logic [ND-1:0] SEG_SELECT_OUT;
  logic [7:0] HEX_OUT;
  logic FRAME_STROBE;
  int checks = 0, errors = 0, t = 0;
  logic [7:0] m_reg [ND+1];
  logic [7:0] m_sh [ND];
  logic [6:0] lut [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  // The bus floats high when nobody drives it, so an undriven bus reads 8'hFF.
  assign BUS_DATA = tb_oe ? tb_data : 'z;
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (BUS_DATA[g]);
  end
  seg7_bus_display #(
    .NUM_DIGITS(ND),
    .BASE_ADDR(BASE),
    .CLK_FREQ_HZ(6400),
    .REFRESH_HZ(100),
    .BLANK_CYCLES(BLANK)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .BUS_DATA(BUS_DATA),
    .BUS_ADDR(BUS_ADDR),
    .BUS_WE(BUS_WE),
    .SEG_SELECT_OUT(SEG_SELECT_OUT),
    .HEX_OUT(HEX_OUT),
    .FRAME_STROBE(FRAME_STROBE)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d after reset)", tag, got, exp, t);
    end
  endtask
  // t counts clock edges since the reset edge; the scan position, PWM phase and frame
  // boundaries all follow from it arithmetically.
  task automatic cyc(input logic rst, input logic we, input logic [7:0] addr, input logic [7:0] data);
    logic [7:0] eh, eb, sh;
    logic [3:0] es;
    logic ef, hit, on;
    int d, slot, pwm, k;
    RESET = rst;
    BUS_WE = we && !rst;
    tb_oe = we && !rst;
    BUS_ADDR = addr;
    tb_data = data;
    hit = int'(addr) >= int'(BASE) && int'(addr) <= int'(BASE) + ND;
    k = int'(addr) - int'(BASE);
    @(posedge CLK);
    if (rst) begin
      foreach (m_reg[i]) m_reg[i] = i == ND ? 8'hF0 : 8'h10;
      foreach (m_sh[i]) m_sh[i] = 8'h10;
      eh = 8'hFF;
      es = 4'hF;
      ef = 1'b0;
      eb = 8'hFF;
      t = 0;
      last_rd = 1'b0;
    end else begin
      slot = t % SLOT;
      d = (t / SLOT) % ND;
      pwm = t % 16;
      sh = m_sh[d];
      on = slot >= BLANK && m_reg[ND][0] && !sh[4] && pwm <= int'(m_reg[ND][7:4]);
      es = on ? ~(4'd1 << d) : 4'hF;
      eh = sh[4] ? 8'hFF : ~{sh[7], lut[sh[3:0]]};
      ef = t == 0 || t % FRAME == FRAME - 1;
      eb = (!we && hit) ? m_reg[k] : 8'hFF;
      if (ef) foreach (m_sh[i]) m_sh[i] = m_reg[i];
      if (we && hit) m_reg[k] = data & (k == ND ? 8'hF1 : 8'h9F);
      last_rd = !we && hit;
      t++;
    end
    #1;
    chk("hex", HEX_OUT, eh);
    chk("anodes", {4'h0, SEG_SELECT_OUT}, {4'h0, es});
    chk("strobe", {7'h0, FRAME_STROBE}, {7'h0, ef});
    if (!tb_oe) chk("bus", BUS_DATA, eb);
  endtask
  // A write never directly follows a read: the read data still owns the bus that cycle.
  task automatic step(input logic rst, input logic we, input logic [7:0] addr, input logic [7:0] data);
    if (we && last_rd) cyc(1'b0, 1'b0, 8'h00, 8'h00);
    cyc(rst, we, addr, data);
  endtask
  task automatic idle();
    step(1'b0, 1'b0, 8'h00, 8'h00);
  endtask
  initial begin
    logic [7:0] a;
    int k;
    step(1'b1, 1'b0, 8'h00, 8'h00);
    step(1'b1, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i <= ND; i++) step(1'b0, 1'b0, BASE + 8'(i), 8'h00);
    step(1'b0, 1'b0, BASE + 8'd5, 8'h00);
    repeat (FRAME) idle();
    step(1'b0, 1'b1, BASE, 8'h00);
    step(1'b0, 1'b1, BASE + 8'd1, 8'h88);
    step(1'b0, 1'b1, BASE + 8'(ND), 8'hF1);
    repeat (2 * FRAME) idle();
    step(1'b0, 1'b1, BASE + 8'(ND), 8'h31);
    repeat (2 * FRAME) idle();
    step(1'b0, 1'b1, BASE + 8'(ND), 8'hF1);
    while (t % FRAME != FRAME - 1) idle();
    step(1'b0, 1'b1, BASE, 8'h05);
    repeat (2 * FRAME) idle();
    step(1'b0, 1'b1, BASE + 8'd5, 8'h3C);
    step(1'b0, 1'b1, 8'h00, 8'h3C);
    for (int i = 0; i <= ND + 1; i++) step(1'b0, 1'b0, BASE + 8'(i), 8'h00);
    while (t % FRAME != 2 * SLOT + SLOT / 2) idle();
    step(1'b1, 1'b0, 8'h00, 8'h00);
    repeat (FRAME + 8) idle();
    repeat (3000) begin
      k = $urandom_range(0, 9);
      a = k <= 5 ? BASE + 8'(k) : k == 6 ? 8'h00 : 8'($urandom);
      step($urandom_range(0, 299) == 0, $urandom_range(0, 1) == 1, a, 8'($urandom));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
